// File: rtl/ecc_mem_scrub_ctrl_if.sv
// Host-side request/response bundle for the ECC memory scrub controller.
// The master (host) issues read/write requests; the slave (controller)
// accepts them and returns one-cycle read response strobes.
interface ecc_mem_scrub_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_corrected;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_corrected
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_corrected
  );
endinterface

// File: rtl/ecc_mem_scrub_ctrl.sv
// ECC memory scrub controller.
// Time-shares one external Hamming SEC codec and one synchronous-read
// codeword RAM port between host requests and a background scrubber.
// Any corrected single-bit error is written back clean and counted.
module ecc_mem_scrub_ctrl #(
  parameter int DATA_W         = 32,
  parameter int CODE_W         = 38,
  parameter int ADDR_W         = 8,
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  ecc_mem_scrub_ctrl_if.slave host,
  input  logic                i_scrub_en,
  output logic [ADDR_W-1:0]   o_scrub_addr,
  output logic [15:0]         o_corr_count,
  output logic [DATA_W-1:0]   o_enc_data,
  input  logic [CODE_W-1:0]   i_enc_code,
  output logic [CODE_W-1:0]   o_dec_code,
  input  logic [DATA_W-1:0]   i_dec_data,
  input  logic                i_dec_err,
  output logic                o_mem_re,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [CODE_W-1:0]   o_mem_wdata,
  input  logic [CODE_W-1:0]   i_mem_rdata
);

  localparam int CNT_W = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCRUB_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_CHK,
    S_WB
  } state_t;

  state_t            r_state;
  logic              r_tag_scrub;     // 1: current read belongs to the scrubber
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_enc_data;      // write data for WR, corrected data for WB
  logic              r_mem_re;
  logic              r_mem_we;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_corrected;
  logic [ADDR_W-1:0] r_scrub_addr;
  logic [15:0]       r_corr_count;
  logic [CNT_W-1:0]  r_scrub_cnt;
  logic              r_scrub_pending;
  logic              w_scrub_start;

  // A scrub only starts from IDLE when no host request competes for the slot.
  assign w_scrub_start = (r_state == S_IDLE) && !host.req_valid && r_scrub_pending;

  // Ready is gated by reset so the host never sees an accept while held in reset.
  assign host.req_ready     = rst_n && (r_state == S_IDLE);
  assign host.rsp_valid     = r_rsp_valid;
  assign host.rsp_rdata     = r_rsp_rdata;
  assign host.rsp_corrected = r_rsp_corrected;

  assign o_scrub_addr = r_scrub_addr;
  assign o_corr_count = r_corr_count;
  assign o_enc_data   = r_enc_data;
  assign o_mem_re     = r_mem_re;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_addr;
  // The encoder is combinational, so the codeword follows enc_data in the same cycle.
  assign o_mem_wdata  = r_mem_we ? i_enc_code : '0;
  // The RAM returns the codeword in CHK; the decoder only sees it then.
  assign o_dec_code   = (r_state == S_CHK) ? i_mem_rdata : '0;

  // Scrub interval timer: counts enabled cycles while nothing is pending, then raises one pending request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scrub_cnt     <= '0;
      r_scrub_pending <= 1'b0;
    end else if (w_scrub_start) begin
      r_scrub_pending <= 1'b0;
    end else if (i_scrub_en && !r_scrub_pending) begin
      if (r_scrub_cnt == CNT_MAX) begin
        r_scrub_cnt     <= '0;
        r_scrub_pending <= 1'b1;
      end else begin
        r_scrub_cnt <= r_scrub_cnt + CNT_W'(1);
      end
    end
  end

  // Main sequencer: arbitrates host vs scrub, drives RAM strobes one cycle ahead as registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_tag_scrub     <= 1'b0;
      r_addr          <= '0;
      r_enc_data      <= '0;
      r_mem_re        <= 1'b0;
      r_mem_we        <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_rsp_rdata     <= '0;
      r_rsp_corrected <= 1'b0;
      r_scrub_addr    <= '0;
      r_corr_count    <= '0;
    end else begin
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_enc_data  <= '0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (host.req_valid) begin
            r_addr      <= host.req_addr;
            r_tag_scrub <= 1'b0;
            if (host.req_we) begin
              r_state    <= S_WR;
              r_mem_we   <= 1'b1;
              r_enc_data <= host.req_wdata;
            end else begin
              r_state  <= S_RD;
              r_mem_re <= 1'b1;
            end
          end else if (r_scrub_pending) begin
            r_addr      <= r_scrub_addr;
            r_tag_scrub <= 1'b1;
            r_state     <= S_RD;
            r_mem_re    <= 1'b1;
          end
        end
        S_WR: begin
          r_state <= S_IDLE;
        end
        S_RD: begin
          r_state <= S_CHK;
        end
        S_CHK: begin
          if (r_tag_scrub) begin
            r_scrub_addr <= r_scrub_addr + ADDR_W'(1);
          end else begin
            r_rsp_valid     <= 1'b1;
            r_rsp_rdata     <= i_dec_data;
            r_rsp_corrected <= i_dec_err;
          end
          if (i_dec_err) begin
            if (r_corr_count != 16'hFFFF) begin
              r_corr_count <= r_corr_count + 16'd1;
            end
            r_state    <= S_WB;
            r_mem_we   <= 1'b1;
            r_enc_data <= i_dec_data;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WB: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ecc_mem_scrub_ctrl.md
Name: ecc_mem_scrub_ctrl

Overview:
- Sequences a combinational Hamming SEC codec (32-bit data, 38-bit codeword) in front of a synchronous-read codeword RAM.
- Shares the single codec and RAM port between host read/write requests and a background scrubber.
- On a corrected single-bit error, writes the clean codeword back to the RAM and counts the event.

Parameters:
DATA_W, 32, data word width
CODE_W, 38, codeword width (DATA_W + 6 parity)
ADDR_W, 8, RAM address width; depth = 2**ADDR_W
SCRUB_INTERVAL, 1024, scrub_en-high cycles between scrub operations (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  host request accepted when valid&ready
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  host address
req_wdata  in  DATA_W  host write data
rsp_valid  out  1  one-cycle read response strobe, no backpressure
rsp_rdata  out  DATA_W  corrected read data
rsp_corrected  out  1  read hit a single-bit error
scrub_en  in  1  enables scrub interval counting
scrub_addr  out  ADDR_W  next address to scrub
corr_count  out  16  saturating corrected-error count
enc_data  out  DATA_W  to codec encoder
enc_code  in  CODE_W  from codec encoder (combinational)
dec_code  out  CODE_W  to codec decoder
dec_data  in  DATA_W  from decoder, corrected data
dec_err  in  1  from decoder, nonzero syndrome (error corrected)
mem_re  out  1  RAM read enable; data on mem_rdata next cycle
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  CODE_W  RAM write codeword = enc_code
mem_rdata  in  CODE_W  RAM read data

Behaviour:
- Reset (rst_n low at edge): state IDLE; rsp_valid, rsp_rdata, rsp_corrected, scrub_addr, corr_count, scrub counter, and scrub_pending all 0; req_ready=0 while rst_n=0.
- Reset mid-operation aborts with no further mem_we/mem_re, no rsp. RAM contents are untouched.
- FSM states: IDLE, WR, RD, CHK, WB.
- IDLE:
  - req_ready=1.
  - If req_valid, latch we/addr/wdata and tag=HOST; go to WR if we, else RD.
  - Else if scrub_pending, latch addr=scrub_addr, tag=SCRUB, clear pending, go to RD.
  - Host has strict priority over scrub start.
- WR (1 cycle): mem_we=1, mem_addr=latched addr, enc_data=latched wdata, mem_wdata=enc_code. Go to IDLE.
- RD (1 cycle): mem_re=1, mem_addr=latched addr. Go to CHK.
- CHK (1 cycle):
  - dec_code=mem_rdata; register dec_data and dec_err.
  - If tag=HOST: rsp_valid=1 in the next cycle, rsp_rdata=dec_data, rsp_corrected=dec_err.
  - If tag=SCRUB: no rsp; scrub_addr increments, wrapping 2**ADDR_W-1 -> 0.
  - If dec_err: corr_count increments, saturating at 0xFFFF; go to WB. Else go to IDLE.
- WB (1 cycle): enc_data=registered corrected data, mem_we=1, mem_addr=latched addr, mem_wdata=enc_code. Go to IDLE.
- Latency:
  - Host write accepted in cycle T: mem_we at T+1.
  - Host read accepted in cycle T: mem_re at T+1, CHK at T+2, rsp_valid at T+3 (WB also at T+3 if corrected).
  - Next accept possible at T+2 (write), T+3 (clean read), T+4 (corrected read).
- req_ready=0 in every non-IDLE state; rsp_rdata/rsp_corrected hold their last values between strobes.
- Outputs not named for a state are 0 in that state (mem_re, mem_we, enc_data, dec_code).
- Scrub counter:
  - Increments each cycle scrub_en=1 and scrub_pending=0.
  - On reaching SCRUB_INTERVAL-1 it sets scrub_pending and returns to 0.
  - Holds while pending; pending never accumulates beyond 1.
  - scrub_en=0 freezes the counter but preserves any existing pending.
- Scrub in progress always completes; host requests wait in IDLE.

Test Plan:
- Reset: rst_n low 2 cycles mid-traffic -> all outputs 0 next cycle, corr_count=0, scrub_addr=0, req_ready=0 during reset.
- Write addr 5 data 0x0000000C at T -> mem_we=1 at T+1 with addr 5, mem_wdata=encoder(0xC). Read addr 5 -> rsp_valid at T+3, rsp_rdata=0xC, rsp_corrected=0, no WB.
- Bench flips codeword bit 3 at addr 5; read -> rsp_rdata=0xC, rsp_corrected=1, mem_we at T+3 with addr 5 and clean codeword, corr_count=1. Re-read -> rsp_corrected=0.
- SCRUB_INTERVAL=8, ADDR_W=2, scrub_en=1, no host traffic, addr 0 corrupted -> scrub read of addr 0 after 8 cycles, write-back, corr_count+1, scrub_addr=1, rsp_valid never set. After 4 scrubs scrub_addr wraps to 0.
- Scrub pending while req_valid held high for 10 requests -> all host requests served first; scrub RD starts in the first IDLE cycle with req_valid=0. A host request arriving during the scrub waits until IDLE.
- rst_n low during WB cycle -> mem_we=0 next cycle, corr_count=0. Force corr_count to 0xFFFF, then another corrected read -> count stays 0xFFFF.
